// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file read port over every register and streams each
// value out as an address-tagged valid/ready beat, keeping a running checksum. Rev 1.0
`default_nettype none

module reg_dump_reader #(
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_src,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   rf_src_q, rf_src_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rf_src_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rf_src_q    <= rf_src_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rf_src_d    = rf_src_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    case (state_q)
      S_IDLE: begin
        // start beats a coincident abort here: abort has nothing to cancel yet
        if (start) begin
          idx_d      = '0;
          rf_src_d   = '0;
          checksum_d = '0;
          busy_d     = 1'b1;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_data_d  = rf_data;
          out_addr_d  = idx_q;
          out_valid_d = 1'b1;
          checksum_d  = checksum_q + rf_data;
          state_d     = S_SEND;
        end
      end

      S_SEND: begin
        // abort wins over a same-cycle handshake; the beat still counts as consumed
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            idx_d    = idx_q + ADDR_W'(1);
            rf_src_d = idx_q + ADDR_W'(1);
            state_d  = S_READ;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rf_src    = rf_src_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed bench with a negedge-write register file model and beat monitor.
// Rev 1.0
`default_nettype none

module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  rf_src;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] rf    [0:14];
  logic [31:0] exp_d [0:14];
  logic [3:0]  q_addr [$];
  logic [31:0] q_data [$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_start = 0;
  int t_done  = -1;
  int n_done  = 0;
  int stall   = 0;
  bit bp_mode = 1'b0;

  always #5 clk = ~clk;

  assign rf_data = (rf_src < 4'd15) ? rf[rf_src] : 32'h0;

  reg_dump_reader #(.NUM_REGS(15), .ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rf_src(rf_src), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Negedge monitor: a beat with valid&ready here is accepted at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q_addr.push_back(out_addr);
        q_data.push_back(out_data);
      end else if (out_valid && bp_mode && q_addr.size() < 15) begin
        check_eq("hold_addr", {28'h0, out_addr}, 32'(q_addr.size()));
        check_eq("hold_data", out_data, exp_d[q_addr.size()]);
      end
      if (done) begin
        n_done++;
        t_done = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!bp_mode) out_ready = 1'b1;
    else if (!out_valid) begin stall = 0; out_ready = 1'b0; end
    else if (stall < 3) begin stall++; out_ready = 1'b0; end
    else out_ready = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    n_done = 0;
    t_done = -1;
  endtask

  task automatic set_rf_linear();
    for (int i = 0; i < 15; i++) begin
      rf[i]    = 32'(i);
      exp_d[i] = 32'(i);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (n_done > 0) break;
    end
    step();
    step();
  endtask

  task automatic check_dump(input string tag, input logic [31:0] exp_sum);
    check_eq({tag, "_beats"}, 32'(q_addr.size()), 32'd15);
    for (int i = 0; i < 15 && i < q_addr.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), {28'h0, q_addr[i]}, 32'(i));
      check_eq($sformatf("%s_data%0d", tag, i), q_data[i], exp_d[i]);
    end
    check_eq({tag, "_sum"}, checksum, exp_sum);
    check_eq({tag, "_ndone"}, 32'(n_done), 32'd1);
    check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    set_rf_linear();
    step(); step();
    check_eq("rst_valid", {31'h0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_done", {31'h0, done}, 32'd0);
    check_eq("rst_sum", checksum, 32'd0);
    check_eq("rst_src", {28'h0, rf_src}, 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    rst = 1'b0;
    step(); step();

    // Basic dump with out_ready tied high
    clear_mon();
    do_start();
    check_eq("basic_busy_rise", {31'h0, busy}, 32'd1);
    step();
    check_eq("basic_first_valid", {31'h0, out_valid}, 32'd1);
    check_eq("basic_first_addr", {28'h0, out_addr}, 32'd0);
    wait_done(60);
    check_dump("basic", 32'd105);
    check_eq("basic_latency", 32'(t_done - t_start), 32'd31);

    // Backpressure: 3 stall cycles on every beat
    clear_mon();
    bp_mode = 1'b1;
    do_start();
    wait_done(200);
    check_dump("bp", 32'd105);
    bp_mode = 1'b0;
    step();

    // Concurrent writes: reg 10 before read is seen, reg 2 after capture is not
    clear_mon();
    do_start();
    @(negedge clk);
    rf[10] = 32'hDEADBEEF;
    exp_d[10] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    rf[2] = 32'h12345678;
    wait_done(60);
    check_dump("wr", 32'hDEADBF4E);
    set_rf_linear();

    // Abort coincident with the handshake of beat 5
    clear_mon();
    do_start();
    for (int i = 0; i < 11; i++) step();
    check_eq("abort_pre_valid", {31'h0, out_valid}, 32'd1);
    check_eq("abort_pre_addr", {28'h0, out_addr}, 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_valid", {31'h0, out_valid}, 32'd0);
    check_eq("abort_busy", {31'h0, busy}, 32'd0);
    check_eq("abort_sum", checksum, 32'd15);
    step(); step(); step();
    check_eq("abort_ndone", 32'(n_done), 32'd0);
    check_eq("abort_beats", 32'(q_addr.size()), 32'd6);
    check_eq("abort_sum_hold", checksum, 32'd15);
    clear_mon();
    do_start();
    wait_done(60);
    check_dump("post_abort", 32'd105);

    // start while busy at beat 7 is ignored
    clear_mon();
    do_start();
    for (int i = 0; i < 15; i++) step();
    check_eq("sb_addr", {28'h0, out_addr}, 32'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(60);
    check_dump("sb", 32'd105);
    check_eq("sb_latency", 32'(t_done - t_start), 32'd31);

    // Asynchronous reset at beat 9
    clear_mon();
    do_start();
    for (int i = 0; i < 19; i++) step();
    check_eq("ar_pre_valid", {31'h0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", {31'h0, out_valid}, 32'd0);
    check_eq("ar_busy", {31'h0, busy}, 32'd0);
    check_eq("ar_sum", checksum, 32'd0);
    check_eq("ar_src", {28'h0, rf_src}, 32'd0);
    check_eq("ar_addr", {28'h0, out_addr}, 32'd0);
    check_eq("ar_data", out_data, 32'd0);
    step();
    rst = 1'b0;
    step();
    clear_mon();
    do_start();
    wait_done(60);
    check_dump("ar_redump", 32'd105);
    check_eq("ar_latency", 32'(t_done - t_start), 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug/readout engine for the 15-entry, 32-bit architectural register file.
- On a start pulse it drives the register file read address through every register, 0 to NUM_REGS-1, and captures each read value.
- Each value is presented as one beat on a valid/ready output stream, tagged with its register address.
- A running 32-bit checksum of all dumped words is kept for the testbench and host.
- It sits beside the pipeline and owns one register file read port (src) during a dump.

Parameters:
- NUM_REGS, 15, number of registers dumped (addresses 0..NUM_REGS-1)
- ADDR_W, 4, register address width
- DATA_W, 32, register data width

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE
- abort  input  1  synchronous cancel of an in-progress dump
- rf_src  output  ADDR_W  read address driven to register file src port
- rf_data  input  DATA_W  combinational read data returned for rf_src
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts the beat when high with out_valid
- out_addr  output  ADDR_W  register index of the current beat
- out_data  output  DATA_W  register value of the current beat
- busy  output  1  high from the first cycle after start is accepted until return to IDLE
- done  output  1  one-cycle pulse after the last beat is accepted
- checksum  output  DATA_W  modulo-2^DATA_W sum of all beats captured in the current/last dump

Behaviour:
- Reset, asynchronous, any state: state=IDLE, rf_src=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, checksum=0, idx=0. A dump in progress is discarded.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - start=1 gives idx<=0, rf_src<=0, checksum<=0, busy<=1, then READ.
  - abort is ignored in IDLE.
- READ:
  - out_data<=rf_data, out_addr<=idx, out_valid<=1.
  - checksum<=checksum+rf_data (carry dropped).
  - Next state is SEND.
- SEND:
  - Holds out_valid, out_addr and out_data stable until handshake (out_valid & out_ready at posedge).
  - On handshake: out_valid<=0.
    - If idx==NUM_REGS-1: go to FIN.
    - Else: idx<=idx+1, rf_src<=idx+1, go to READ.
- FIN:
  - done<=1 for exactly one cycle, busy<=0, next state IDLE.
  - checksum holds its value until the next accepted start.
- Latency and throughput:
  - Minimum 2 cycles per register.
  - With out_ready tied high: first beat valid 2 posedges after start is sampled; done high 2*NUM_REGS+1 cycles after start is sampled.
- Register file coherence:
  - The register file writes on negedge; this block samples rf_data on posedge in READ.
  - A write landing before that posedge for a not-yet-read address is reflected in the dump.
  - A write to an address already captured is not reflected.
  - No snapshot or locking is required.
- start while busy or in FIN: ignored, with no restart.
- abort in READ or SEND:
  - Next cycle: state=IDLE, out_valid=0, busy=0, no done pulse.
  - checksum keeps its partial value.
  - An abort coincident with a handshake wins; the beat counts as consumed.
- start and abort together in IDLE: start is accepted.
- out_ready while out_valid=0: no effect.
- rf_src remains at its last value when idle; the register file read is harmless.

Test Plan:
- Basic dump: reset (RF holds reg[i]=i), out_ready=1, pulse start → 15 beats with out_addr 0..14 and out_data 0..14 in order; checksum=105; done pulses once, 31 cycles after start is sampled; busy then falls.
- Backpressure: out_ready low for 3 cycles on every beat → each beat holds addr/data stable while stalled; no beat is duplicated or lost; final checksum=105.
- Concurrent write: during the dump, write 0xDEADBEEF to reg 10 while idx<10 → beat 10 data=0xDEADBEEF. Repeat with a write to reg 2 after beat 2 is captured → beat 2 keeps 2.
- Abort: abort during SEND of beat 5 → next cycle out_valid=0, busy=0, no done; checksum=0+1+2+3+4+5=15. A following start runs a full dump again with checksum=105.
- Start while busy: pulse start at beat 7 → ignored; beat sequence continues to 14 with a single done.
- Reset mid-dump: assert rst asynchronously at beat 9 → all outputs zero immediately. After release, start yields a fresh dump from addr 0.
